// File: rtl/logic_unit_pipe_pkg.sv
// Shared opcode definitions for the bitwise logic unit and the ALU decode.
// The 3-bit opcode space is fully used; there are no reserved encodings.
package logic_unit_pipe_pkg;

    typedef enum logic [2:0] {
        OP_NOT  = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_XOR  = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    localparam int unsigned FLAG_BITS = 3;

endpackage

// File: rtl/logic_unit_pipe_core.sv
// Purely combinational bitwise function and result flags for the logic unit.
// Operand b is ignored for NOT and PASS.
module logic_core
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] res,
    output logic             zero,
    output logic             ones,
    output logic             par
);

    function automatic logic calc_par(input logic [WIDTH-1:0] value);
        return ^value;
    endfunction

    logic [WIDTH-1:0] res_s;

    // Opcode decode into the bitwise result
    always_comb begin
        res_s = '0;
        case (op)
            OP_NOT:  res_s = ~a;
            OP_AND:  res_s = a & b;
            OP_OR:   res_s = a | b;
            OP_XOR:  res_s = a ^ b;
            OP_NAND: res_s = ~(a & b);
            OP_NOR:  res_s = ~(a | b);
            OP_XNOR: res_s = ~(a ^ b);
            OP_PASS: res_s = a;
            default: res_s = a;
        endcase
    end

    assign res  = res_s;
    assign zero = (res_s == '0);
    assign ones = &res_s;
    assign par  = calc_par(res_s);

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with an output register plus a skid register,
// so one cycle of downstream stall is absorbed without dropping a beat.
module logic_unit_pipe
    import logic_unit_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_par
);

    localparam int BEAT_W = WIDTH + FLAG_BITS;

    logic [WIDTH-1:0]  core_res_s;
    logic              core_zero_s;
    logic              core_ones_s;
    logic              core_par_s;
    logic [BEAT_W-1:0] new_beat_s;
    logic              accept_s;
    logic              pop_s;

    logic [BEAT_W-1:0] or_beat_r;
    logic [BEAT_W-1:0] sk_beat_r;
    logic              or_valid_r;
    logic              sk_valid_r;

    logic_core #(.WIDTH(WIDTH)) u_core (
        .op   (op),
        .a    (a),
        .b    (b),
        .res  (core_res_s),
        .zero (core_zero_s),
        .ones (core_ones_s),
        .par  (core_par_s)
    );

    // Flags are packed with the data so they always travel with their beat
    assign new_beat_s = {core_par_s, core_ones_s, core_zero_s, core_res_s};

    assign in_ready = rst_n & ~sk_valid_r;
    assign accept_s = in_valid & in_ready;
    assign pop_s    = or_valid_r & out_ready;

    // Output/skid register update, all decisions from pre-edge state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            or_beat_r  <= '0;
            sk_beat_r  <= '0;
            or_valid_r <= 1'b0;
            sk_valid_r <= 1'b0;
        end else if (pop_s) begin
            if (sk_valid_r) begin
                or_beat_r  <= sk_beat_r;
                sk_valid_r <= 1'b0;
            end else if (accept_s) begin
                or_beat_r  <= new_beat_s;
            end else begin
                or_valid_r <= 1'b0;
            end
        end else if (accept_s) begin
            if (!or_valid_r) begin
                or_beat_r  <= new_beat_s;
                or_valid_r <= 1'b1;
            end else begin
                sk_beat_r  <= new_beat_s;
                sk_valid_r <= 1'b1;
            end
        end else begin
            or_beat_r <= or_beat_r;
        end
    end

    assign out_valid = or_valid_r;
    assign result    = or_beat_r[WIDTH-1:0];
    assign flag_zero = or_beat_r[WIDTH];
    assign flag_ones = or_beat_r[WIDTH+1];
    assign flag_par  = or_beat_r[WIDTH+2];

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed and randomised self-checking bench for logic_unit_pipe at WIDTH=16.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_zero;
    logic        flag_ones;
    logic        flag_par;

    int errors = 0;
    int checks = 0;

    logic_unit_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_zero (flag_zero),
        .flag_ones (flag_ones),
        .flag_par  (flag_par)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Reference: {par, ones, zero, result}
    function automatic logic [18:0] ref_beat(input logic [2:0] o, input logic [15:0] x,
                                             input logic [15:0] y);
        logic [15:0] r;
        case (o)
            3'd0:    r = ~x;
            3'd1:    r = x & y;
            3'd2:    r = x | y;
            3'd3:    r = x ^ y;
            3'd4:    r = ~(x & y);
            3'd5:    r = ~(x | y);
            3'd6:    r = ~(x ^ y);
            default: r = x;
        endcase
        return {^r, (r == 16'hFFFF), (r == 16'h0000), r};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = 3'd0; a = 16'h0000; b = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h want 0000", result); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_ops();
        logic [15:0] exp_tab [8];
        exp_tab = '{16'h0F0F, 16'hF000, 16'hFFF0, 16'h0FF0, 16'h0FFF, 16'h000F, 16'hF00F, 16'hF0F0};
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; op = 3'(i); a = 16'hF0F0; b = 16'hFF00;
            @(negedge clk);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || result !== exp_tab[i]) begin
                errors++;
                $display("FAIL op%0d: got valid=%b result=%h want valid=1 result=%h", i, out_valid, result, exp_tab[i]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        in_valid = 1'b1; op = 3'd1; a = 16'hAAAA; b = 16'h5555;
        @(negedge clk);
        checks++;
        if (result !== 16'h0000 || flag_zero !== 1'b1 || flag_ones !== 1'b0 || flag_par !== 1'b0) begin
            errors++;
            $display("FAIL flags_and: got %h z=%b o=%b p=%b want 0000 z=1 o=0 p=0", result, flag_zero, flag_ones, flag_par);
        end
        op = 3'd2;
        @(negedge clk);
        checks++;
        if (result !== 16'hFFFF || flag_zero !== 1'b0 || flag_ones !== 1'b1 || flag_par !== 1'b0) begin
            errors++;
            $display("FAIL flags_or: got %h z=%b o=%b p=%b want FFFF z=0 o=1 p=0", result, flag_zero, flag_ones, flag_par);
        end
        op = 3'd7; a = 16'h0001;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (result !== 16'h0001 || flag_zero !== 1'b0 || flag_par !== 1'b1) begin
            errors++;
            $display("FAIL flags_pass: got %h z=%b p=%b want 0001 z=0 p=1", result, flag_zero, flag_par);
        end
        @(negedge clk);
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd0; a = 16'h0000;
        @(negedge clk);
        a = 16'hFFFF;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b want 0", in_ready); end
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'hFFFF) begin
            errors++; $display("FAIL stall_hold: got valid=%b result=%h want 1 FFFF", out_valid, result);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h0000) begin
            errors++; $display("FAIL stall_second: got valid=%b result=%h want 1 0000", out_valid, result);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL stall_drain: got valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_random();
        logic [18:0] exp_q [$];
        logic [18:0] got;
        logic [18:0] exp;
        logic [15:0] prev_result;
        logic        prev_stall;
        int sent;
        int cycles;
        sent = 0; cycles = 0; prev_stall = 1'b0; prev_result = 16'h0000;
        while ((sent < 1000 || exp_q.size() != 0) && cycles < 20000) begin
            @(negedge clk);
            cycles++;
            if (prev_stall) begin
                checks++;
                if (result !== prev_result) begin
                    errors++; $display("FAIL rand_hold: got %h want %h", result, prev_result);
                end
            end
            in_valid  = (sent < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            out_ready = (sent < 1000) ? ($urandom_range(0, 2) != 0) : 1'b1;
            op = 3'($urandom_range(0, 7));
            a  = 16'($urandom);
            b  = 16'($urandom);
            if (out_valid && out_ready) begin
                got = {flag_par, flag_ones, flag_zero, result};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra: got unexpected beat %h", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++; $display("FAIL rand_beat: got %h want %h", got, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_beat(op, a, b));
                sent++;
            end
            prev_stall  = out_valid && !out_ready;
            prev_result = result;
        end
        in_valid = 1'b0;
        checks++;
        if (sent != 1000 || exp_q.size() != 0) begin
            errors++; $display("FAIL rand_complete: got sent=%0d pending=%0d want 1000 0", sent, exp_q.size());
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rand_empty: got valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_full();
        int pops;
        out_ready = 1'b0;
        in_valid = 1'b1; op = 3'd7; a = 16'h1111;
        @(negedge clk);
        a = 16'h2222;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++; $display("FAIL full_before_reset: got in_ready=%b valid=%b want 0 1", in_ready, out_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 16'h0000) begin
            errors++; $display("FAIL full_reset: got valid=%b in_ready=%b result=%h want 0 0 0000", out_valid, in_ready, result);
        end
        rst_n = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; a = 16'h3333;
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 16'h3333) begin
            errors++; $display("FAIL after_reset_beat: got valid=%b result=%h want 1 3333", out_valid, result);
        end
        pops = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (out_valid) pops++;
        end
        checks++;
        if (pops != 0) begin errors++; $display("FAIL after_reset_extra: got %0d extra beats want 0", pops); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_flags();
        test_stall();
        test_random();
        test_reset_full();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
